// File: rtl/demo_bus_pkg.sv
// Shared encodings for the demo bus: transfer mode and responder FSM states.
package demo_bus_pkg;

  typedef logic [1:0] state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/demo_slave_mem.sv
// Single-port local memory with synchronous write and synchronous read.
// Contents are intentionally not reset.
module demo_slave_mem #(
  parameter int ADDR_BITS  = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/demo_slave_responder.sv
// Bus slave responder: captures one request, inserts wait states, accesses
// local memory and returns a single-cycle response.
module demo_slave_responder
  import demo_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_ADDR_BITS = 5,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  input  logic                  s_mode,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rvalid,
  output logic                  s_err
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    in_range;
  logic                    mem_we;
  logic                    mem_re;
  logic                    resp_read;

  assign in_range   = (addr_q[ADDR_WIDTH-1:MEM_ADDR_BITS] == '0);
  assign mem_we     = (state == ST_ACCESS) && (mode_q == MODE_WRITE) && in_range;
  assign mem_re     = (state == ST_ACCESS) && (mode_q == MODE_READ) && in_range;
  assign resp_read  = (state == ST_RESP) && (mode_q == MODE_READ);
  assign resp_rdata = in_range ? mem_rdata : '0;

  // The request is latched only in IDLE, so the master may change its inputs
  // freely while a transfer is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            mode_q   <= s_mode;
            addr_q   <= s_addr;
            wdata_q  <= s_wdata;
            wait_cnt <= '0;
            state    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) state <= ST_ACCESS;
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Remember the last returned read word so s_rdata stays stable outside RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else if (resp_read) rdata_q <= resp_rdata;
  end

  assign s_ready  = (state == ST_IDLE);
  assign s_rvalid = resp_read;
  assign s_err    = (state == ST_RESP) && !in_range;
  assign s_rdata  = resp_read ? resp_rdata : rdata_q;

  demo_slave_mem #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q[MEM_ADDR_BITS-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
